// File: rtl/spram_uart_dump.sv
// -----------------------------------------------------------------------------
// spram_uart_dump
//
// Reads a block of 16-bit words from an SB_SPRAM256KA port and streams them to
// a UART transmitter as bytes over a valid/ready handshake. Intended as the
// read-back path triggered by the host to dump SPRAM contents.
//
// Build option:
//   SPRAM_DUMP_HEX_EN  defined   -> each word goes out as 4 uppercase ASCII hex
//                                   digits (MS nibble first) followed by CR LF,
//                                   6 bytes per word.
//                      undefined -> raw big-endian binary, 2 bytes per word.
//
// Parameters:
//   ADDR_W  SPRAM word-address width; addresses wrap modulo 2**ADDR_W
//   RD_LAT  cycles from ram_addr/ram_cs to valid ram_rdata (1..3)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       1-cycle request, only honoured while idle
//   start_addr  first word address, latched with start
//   word_count  number of words to dump, latched with start (0 allowed)
//   abort       stop at the next byte boundary
//   ram_addr    SPRAM word address
//   ram_cs      SPRAM chip-select / read strobe (one cycle per word)
//   ram_rdata   SPRAM read data
//   tx_data     byte to transmit
//   tx_valid    tx_data valid
//   tx_ready    transmitter accepts (transfer on tx_valid && tx_ready)
//   busy        high from the cycle after an accepted start until done
//   done        1-cycle pulse when the dump ends (normal or aborted)
// -----------------------------------------------------------------------------
module spram_uart_dump #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  input  logic [15:0]       ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_SEND,
    S_FIN
  } state_t;

`ifdef SPRAM_DUMP_HEX_EN
  localparam int BYTES_PER_WORD = 6;
`else
  localparam int BYTES_PER_WORD = 2;
`endif

  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_WORD - 1);
  localparam logic [1:0] LAT_LAST  = 2'(RD_LAT - 1);
  localparam logic [ADDR_W:0] ONE_WORD = (ADDR_W+1)'(1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remain_q;
  logic [15:0]       word_q;
  logic [2:0]        byte_idx;
  logic [1:0]        lat_cnt;
  logic              abort_q;
  logic              done_q;

  logic              xfer;
  logic              last_byte;
  logic              stop_req;
  logic [7:0]        byte_sel;

`ifdef SPRAM_DUMP_HEX_EN
  // 'A'..'F' = 8'h41 + (n - 10) = 8'h37 + n
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) hex_ascii = 8'h30 + {4'h0, n};
    else           hex_ascii = 8'h37 + {4'h0, n};
  endfunction
`endif

  assign xfer      = (state == S_SEND) && tx_ready;
  assign last_byte = (byte_idx == LAST_BYTE);
  // An abort seen earlier in this handshake is remembered until the byte goes.
  assign stop_req  = abort || abort_q;

  always_comb begin
    byte_sel = 8'h00;
`ifdef SPRAM_DUMP_HEX_EN
    case (byte_idx)
      3'd0:    byte_sel = hex_ascii(word_q[15:12]);
      3'd1:    byte_sel = hex_ascii(word_q[11:8]);
      3'd2:    byte_sel = hex_ascii(word_q[7:4]);
      3'd3:    byte_sel = hex_ascii(word_q[3:0]);
      3'd4:    byte_sel = 8'h0D;
      default: byte_sel = 8'h0A;
    endcase
`else
    byte_sel = byte_idx[0] ? word_q[7:0] : word_q[15:8];
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        // start has priority over abort while idle
        if (start) state_nx = (word_count == '0) ? S_FIN : S_RD;
      end
      S_RD: begin
        state_nx = abort ? S_FIN : S_WAIT;
      end
      S_WAIT: begin
        if (abort)                    state_nx = S_FIN;
        else if (lat_cnt == LAT_LAST) state_nx = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          if (stop_req)                     state_nx = S_FIN;
          else if (last_byte)               state_nx = (remain_q == ONE_WORD) ? S_FIN : S_RD;
        end
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---- state register and datapath ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      word_q   <= '0;
      byte_idx <= '0;
      lat_cnt  <= '0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      // done follows FIN by one cycle, so it coincides with busy falling
      done_q <= (state == S_FIN);
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q   <= start_addr;
            remain_q <= word_count;
            abort_q  <= 1'b0;
          end
        end
        S_RD: begin
          lat_cnt <= '0;
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt + 2'd1;
          if (lat_cnt == LAT_LAST) begin
            word_q   <= ram_rdata;
            byte_idx <= '0;
          end
        end
        S_SEND: begin
          if (abort) abort_q <= 1'b1;
          if (xfer) begin
            byte_idx <= byte_idx + 3'd1;
            if (last_byte) begin
              remain_q <= remain_q - ONE_WORD;
              addr_q   <= addr_q + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_addr = addr_q;
  assign ram_cs   = (state == S_RD);
  assign tx_valid = (state == S_SEND);
  assign tx_data  = (state == S_SEND) ? byte_sel : 8'h00;
  assign busy     = (state != S_IDLE);
  assign done     = done_q;

endmodule
